// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, S-box, round-count lookup and iterative FSM states.
package aes_pkg;

    typedef logic [14:0][127:0] round_keys_t;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_iter_state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nr_of(input logic [1:0] key_mode);
        return key_mode == 2'b00 ? 4'd10 : key_mode == 2'b01 ? 4'd12 : 4'd14;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_encryption_iter_round.sv
// aes_round_comb: one combinational AES round; mix_en=0 skips MixColumns for the final round.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    input  logic         mix_en,
    output logic [127:0] state_o
);

    logic [127:0] sb, sr, mc;

    // Byte n of the block sits at bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = SBOX[state_i[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
        for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    assign state_o = (mix_en ? mc : sr) ^ key_i;

endmodule

// File: rtl/aes_encryption_iter.sv
// aes_encryption_iter: iterative AES-128/192/256 encryptor, one round per clock.
// Define AES_ENC_BACKTOBACK_EN to accept the next block in the same cycle as the output handshake.
module aes_encryption_iter
    import aes_pkg::*;
#(
    parameter int TDATA_WIDTH = 128,
    parameter int MAX_ROUNDS  = 14
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [TDATA_WIDTH-1:0] aes_in_tdata,
    input  logic                   aes_in_tvalid,
    input  logic                   aes_in_tlast,
    output logic                   aes_in_tready,
    input  logic [1:0]             key_mode,
    input  round_keys_t            round_keys,
    input  logic                   round_keys_valid,
    output logic [TDATA_WIDTH-1:0] aes_out_tdata,
    output logic                   aes_out_tvalid,
    output logic                   aes_out_tlast,
    input  logic                   aes_out_tready,
    output logic                   busy
);

    if (TDATA_WIDTH != 128 || MAX_ROUNDS != 14) begin : g_bad_cfg
        $error("aes_encryption_iter supports only TDATA_WIDTH=128 and MAX_ROUNDS=14");
    end

    aes_iter_state_t st_q, st_d;
    logic [127:0]    state_q, state_d, round_out;
    logic [3:0]      nr_q, nr_d, rnd_q, rnd_d;
    logic            last_q, last_d, last_rnd, in_hs;

    assign last_rnd = rnd_q == nr_q;

    aes_round_comb u_round (
        .state_i (state_q),
        .key_i   (round_keys[rnd_q]),
        .mix_en  (!last_rnd),
        .state_o (round_out)
    );

    // Gated by resetn so ready reads low while reset is held, whatever round_keys_valid does.
`ifdef AES_ENC_BACKTOBACK_EN
    assign aes_in_tready = resetn && round_keys_valid && (st_q == IDLE || (st_q == DONE && aes_out_tready));
`else
    assign aes_in_tready = resetn && round_keys_valid && st_q == IDLE;
`endif
    assign in_hs = aes_in_tvalid && aes_in_tready;

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        nr_d    = nr_q;
        rnd_d   = rnd_q;
        last_d  = last_q;
        if (st_q == ROUND) begin
            state_d = round_out;
            rnd_d   = last_rnd ? rnd_q : rnd_q + 4'd1;
            st_d    = last_rnd ? DONE : ROUND;
        end
        if (st_q == DONE && aes_out_tready) st_d = IDLE;
        if (in_hs) begin
            state_d = aes_in_tdata ^ round_keys[0];
            nr_d    = nr_of(key_mode);
            last_d  = aes_in_tlast;
            rnd_d   = 4'd1;
            st_d    = ROUND;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q    <= IDLE;
            state_q <= '0;
            nr_q    <= '0;
            rnd_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            nr_q    <= nr_d;
            rnd_q   <= rnd_d;
            last_q  <= last_d;
        end
    end

    assign aes_out_tvalid = st_q == DONE;
    assign aes_out_tdata  = aes_out_tvalid ? state_q : '0;
    assign aes_out_tlast  = aes_out_tvalid && last_q;
    assign busy           = st_q != IDLE;

endmodule

// File: tb/tb_aes_encryption_iter.sv
// tb_aes_encryption_iter: directed FIPS-197 vectors, backpressure, streaming and reset abort.
module tb_aes_encryption_iter;
    import aes_pkg::*;

    logic         clk = 1'b0, resetn = 1'b0;
    logic [127:0] in_tdata = '0;
    logic         in_tvalid = 1'b0, in_tlast = 1'b0, in_tready;
    logic [1:0]   key_mode = 2'b00;
    round_keys_t  rk = '0;
    logic         rk_valid = 1'b0;
    logic [127:0] out_tdata;
    logic         out_tvalid, out_tlast, busy;
    logic         out_tready = 1'b0;
    int           checks = 0, errors = 0, cyc = 0;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
`ifdef AES_ENC_BACKTOBACK_EN
    localparam bit BTB = 1'b1;
    localparam int GAP = 1;
`else
    localparam bit BTB = 1'b0;
    localparam int GAP = 2;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_encryption_iter dut (
        .clk              (clk),
        .resetn           (resetn),
        .aes_in_tdata     (in_tdata),
        .aes_in_tvalid    (in_tvalid),
        .aes_in_tlast     (in_tlast),
        .aes_in_tready    (in_tready),
        .key_mode         (key_mode),
        .round_keys       (rk),
        .round_keys_valid (rk_valid),
        .aes_out_tdata    (out_tdata),
        .aes_out_tvalid   (out_tvalid),
        .aes_out_tlast    (out_tlast),
        .aes_out_tready   (out_tready),
        .busy             (busy)
    );

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
    endfunction

    // FIPS-197 key expansion of the leading nk words of KEY.
    function automatic round_keys_t expand(input int nk);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rc = 8'h01;
        logic [255:0] key = KEY;
        round_keys_t  k = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk == 8 && i % nk == 4) t = sub_word(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < nk + 7; r++) k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return k;
    endfunction

    task automatic send(input logic [127:0] d, input logic [1:0] m, input logic l, output bit ok, output int t);
        ok = 1'b0;
        t = 0;
        in_tdata = d; key_mode = m; in_tlast = l; in_tvalid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            ok = in_tready;
            @(posedge clk); #1;
            t = cyc;
        end
        in_tvalid = 1'b0;
    endtask

    task automatic wait_out(output bit ok, output logic [127:0] d, output logic l, output int t);
        ok = 1'b0; d = '0; l = 1'b0; t = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (out_tvalid) begin
                if (t == 0) t = cyc;
                if (out_tready) begin
                    ok = 1'b1; d = out_tdata; l = out_tlast;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; rk_valid = 1'b1; out_tready = 1'b1;
        #12;
        checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", out_tvalid); end
        checks++; if (out_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", out_tdata); end
        checks++; if (out_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", out_tlast); end
        checks++; if (in_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", in_tready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_tready !== 1'b1) begin errors++; $display("FAIL idle_tready: got %b want 1", in_tready); end
    endtask

    task automatic test_aes128();
        bit ok_i, ok_o; int ta, te; logic [127:0] d; logic l;
        rk = expand(4); out_tready = 1'b1;
        send(PT, 2'b00, 1'b1, ok_i, ta);
        wait_out(ok_o, d, l, te);
        checks++; if (!(ok_i && ok_o)) begin errors++; $display("FAIL aes128_hs: in=%0b out=%0b want 1 1", ok_i, ok_o); end
        checks++; if (d !== C128) begin errors++; $display("FAIL aes128_data: got %h want %h", d, C128); end
        checks++; if (te - ta != 10) begin errors++; $display("FAIL aes128_latency: got %0d want 10", te - ta); end
        checks++; if (l !== 1'b1) begin errors++; $display("FAIL aes128_tlast: got %b want 1", l); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL aes128_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_aes192();
        bit ok_i, ok_o; int ta, te; logic [127:0] d; logic l;
        rk = expand(6); out_tready = 1'b1;
        send(PT, 2'b01, 1'b0, ok_i, ta);
        wait_out(ok_o, d, l, te);
        checks++; if (!(ok_i && ok_o)) begin errors++; $display("FAIL aes192_hs: in=%0b out=%0b want 1 1", ok_i, ok_o); end
        checks++; if (d !== C192) begin errors++; $display("FAIL aes192_data: got %h want %h", d, C192); end
        checks++; if (te - ta != 12) begin errors++; $display("FAIL aes192_latency: got %0d want 12", te - ta); end
        checks++; if (l !== 1'b0) begin errors++; $display("FAIL aes192_tlast: got %b want 0", l); end
    endtask

    task automatic test_aes256();
        bit ok_i, ok_o; int ta, te; logic [127:0] d; logic l;
        rk = expand(8); out_tready = 1'b1;
        send(PT, 2'b10, 1'b0, ok_i, ta);
        key_mode = 2'b00; in_tlast = 1'b1;
        wait_out(ok_o, d, l, te);
        checks++; if (!(ok_i && ok_o)) begin errors++; $display("FAIL aes256_hs: in=%0b out=%0b want 1 1", ok_i, ok_o); end
        checks++; if (d !== C256) begin errors++; $display("FAIL aes256_data: got %h want %h", d, C256); end
        checks++; if (te - ta != 14) begin errors++; $display("FAIL aes256_latency: got %0d want 14", te - ta); end
        checks++; if (l !== 1'b0) begin errors++; $display("FAIL aes256_tlast_sampled: got %b want 0", l); end
        in_tlast = 1'b0;
    endtask

    task automatic test_mode11();
        bit ok_i, ok_o; int ta, te; logic [127:0] d; logic l;
        rk = expand(8); out_tready = 1'b1;
        send(PT, 2'b11, 1'b0, ok_i, ta);
        wait_out(ok_o, d, l, te);
        checks++; if (d !== C256) begin errors++; $display("FAIL mode11_data: got %h want %h", d, C256); end
        checks++; if (te - ta != 14) begin errors++; $display("FAIL mode11_latency: got %0d want 14", te - ta); end
    endtask

    task automatic test_backpressure();
        bit ok_i, seen = 1'b0; int ta, beats = 0; logic [127:0] d = '0;
        rk = expand(4); out_tready = 1'b0;
        send(PT, 2'b00, 1'b1, ok_i, ta);
        for (int i = 0; i < 30 && !seen; i++) begin
            if (out_tvalid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (!(ok_i && seen)) begin errors++; $display("FAIL bp_valid: in=%0b seen=%0b want 1 1", ok_i, seen); end
        in_tdata = ~PT; in_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_tvalid, out_tdata, out_tlast, in_tready} !== {1'b1, C128, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL bp_stall_%0d: got v=%b d=%h l=%b rdy=%b want v=1 d=%h l=1 rdy=0", i, out_tvalid, out_tdata, out_tlast, in_tready, C128);
            end
        end
        in_tvalid = 1'b0; out_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_tvalid && out_tready) begin beats++; d = out_tdata; end
            @(posedge clk); #1;
        end
        checks++; if (beats != 1) begin errors++; $display("FAIL bp_beats: got %0d want 1", beats); end
        checks++; if (d !== C128) begin errors++; $display("FAIL bp_release_data: got %h want %h", d, C128); end
    endtask

    task automatic test_stream();
        logic [1:0]   modes [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        logic [127:0] exp_d [4] = '{C128, C192, C256, C128};
        int           nks [4] = '{4, 6, 8, 4};
        int           nrs [4] = '{10, 12, 14, 10};
        int           ta [4], te [4];
        bit           oki [4], oko [4];
        logic [127:0] d [4];
        logic         l [4];
        out_tready = 1'b1;
        fork
            for (int n = 0; n < 4; n++) begin
                for (int i = 0; i < 40 && busy && !(BTB && out_tvalid); i++) begin @(posedge clk); #1; end
                rk = expand(nks[n]);
                send(PT, modes[n], n == 3, oki[n], ta[n]);
            end
            for (int n = 0; n < 4; n++) wait_out(oko[n], d[n], l[n], te[n]);
        join
        for (int n = 0; n < 4; n++) begin
            checks++; if (!(oki[n] && oko[n])) begin errors++; $display("FAIL stream_hs_%0d: in=%0b out=%0b want 1 1", n, oki[n], oko[n]); end
            checks++; if (d[n] !== exp_d[n]) begin errors++; $display("FAIL stream_data_%0d: got %h want %h", n, d[n], exp_d[n]); end
            checks++; if (l[n] !== (n == 3)) begin errors++; $display("FAIL stream_tlast_%0d: got %b want %b", n, l[n], n == 3); end
            if (n < 3) begin
                checks++;
                if (ta[n+1] - ta[n] != nrs[n] + GAP) begin
                    errors++; $display("FAIL stream_gap_%0d: got %0d want %0d", n, ta[n+1] - ta[n], nrs[n] + GAP);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        bit ok_i, ok_o; int ta, te, spurious = 0; logic [127:0] d; logic l;
        rk = expand(4); out_tready = 1'b1;
        send(PT, 2'b00, 1'b1, ok_i, ta);
        repeat (4) @(posedge clk);
        #2 resetn = 1'b0;
        #2;
        checks++; if ({out_tvalid, out_tlast, in_tready, busy} !== 4'b0000) begin errors++; $display("FAIL abort_outputs: got v=%b l=%b rdy=%b busy=%b want 0 0 0 0", out_tvalid, out_tlast, in_tready, busy); end
        checks++; if (out_tdata !== '0) begin errors++; $display("FAIL abort_tdata: got %h want 0", out_tdata); end
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_tvalid) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL abort_no_output: got %0d valid cycles want 0", spurious); end
        send(PT, 2'b00, 1'b0, ok_i, ta);
        wait_out(ok_o, d, l, te);
        checks++; if (d !== C128) begin errors++; $display("FAIL abort_recover_data: got %h want %h", d, C128); end
        rk_valid = 1'b0; in_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if ({in_tready, busy} !== 2'b00) begin errors++; $display("FAIL nokeys_%0d: got rdy=%b busy=%b want 0 0", i, in_tready, busy); end
            @(posedge clk); #1;
        end
        in_tvalid = 1'b0; rk_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_mode11();
        test_backpressure();
        test_stream();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
